// File: rtl/pipeline_mem_stage_if.sv
// Data-memory req/gnt/rvalid bus between the MEM stage (master) and data memory (slave).
interface pipeline_mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/pipeline_mem_stage.sv
// RV32 MEM stage: latches EX results, resolves redirects, runs the data-memory handshake.
// Optional MEM_MISALIGN_TRAP_EN: misaligned memory ops trap instead of issuing a request.
//
// state | meaning
// IDLE  | ready to accept an instruction from EX
// REQ   | dmem_req asserted, waiting for gnt
// RSP   | load granted, waiting for rvalid
module pipeline_mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [31:0]          PC_out_EX,
    input  logic [31:0]          PC4_out_EX,
    input  logic [31:0]          ALU_out_EX,
    input  logic [31:0]          Rs2_out_EX,
    input  logic                 zero_out_EX,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic                 branch_in,
    input  logic                 jump_in,
    input  logic                 reg_write_in,
    input  logic [1:0]           mem_to_reg_in,
    input  logic [4:0]           rd_in,
    output logic                 stall_mem,
    output logic                 pc_src,
    output logic [31:0]          pc_target,
    pipeline_mem_stage_if.master dmem,
    output logic                 wb_valid,
    output logic [31:0]          wb_alu,
    output logic [31:0]          wb_load,
    output logic [31:0]          wb_pc4,
    output logic [1:0]           wb_mem_to_reg,
    output logic [4:0]           wb_rd,
    output logic                 wb_reg_write,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                 misalign_trap,
`endif
    output logic                 bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  tmo_cnt;
    logic [31:0] alu_q, wdata_q, pc4_q;
    logic        we_q, reg_write_q;
    logic [1:0]  m2r_q;
    logic [4:0]  rd_q;

    logic is_mem, misaligned;
    logic accept, go_req, wb_mem, load_done, timeout_hit;

    assign is_mem = mem_read_in | mem_write_in;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = is_mem && (ALU_out_EX[1:0] != 2'b00);
    assign dmem.addr  = alu_q;
`else
    assign misaligned = 1'b0;
    assign dmem.addr  = {alu_q[31:2], 2'b00};
`endif

    assign stall_mem  = (state != IDLE);
    assign dmem.req   = (state == REQ);
    assign dmem.we    = (state == REQ) & we_q;
    assign dmem.wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Timeout wins over a same-cycle gnt/rvalid so the stall bound is exact.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        go_req      = 1'b0;
        wb_mem      = 1'b0;
        load_done   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (is_mem && !misaligned) begin
                        go_req     = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (tmo_cnt == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else if (dmem.gnt) begin
                    wb_mem     = we_q;
                    state_next = we_q ? IDLE : RSP;
                end
            end
            RSP: begin
                if (tmo_cnt == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else if (dmem.rvalid) begin
                    load_done  = 1'b1;
                    wb_mem     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              tmo_cnt <= '0;
        else if (go_req)         tmo_cnt <= '0;
        else if (state != IDLE)  tmo_cnt <= tmo_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q         <= '0;
            wdata_q       <= '0;
            pc4_q         <= '0;
            we_q          <= 1'b0;
            reg_write_q   <= 1'b0;
            m2r_q         <= '0;
            rd_q          <= '0;
            pc_src        <= 1'b0;
            pc_target     <= '0;
            wb_valid      <= 1'b0;
            wb_alu        <= '0;
            wb_load       <= '0;
            wb_pc4        <= '0;
            wb_mem_to_reg <= '0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            bus_err       <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
        end else begin
            pc_src   <= 1'b0;
            wb_valid <= 1'b0;
            bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
            if (accept) begin
                alu_q       <= ALU_out_EX;
                wdata_q     <= Rs2_out_EX;
                pc4_q       <= PC4_out_EX;
                we_q        <= mem_write_in;
                reg_write_q <= reg_write_in;
                m2r_q       <= mem_to_reg_in;
                rd_q        <= rd_in;
                pc_src      <= jump_in | (branch_in & zero_out_EX);
                pc_target   <= PC_out_EX;
                // Non-memory (or trapped) ops retire straight from the EX inputs.
                if (!go_req) begin
                    wb_valid      <= 1'b1;
                    wb_alu        <= ALU_out_EX;
                    wb_pc4        <= PC4_out_EX;
                    wb_mem_to_reg <= mem_to_reg_in;
                    wb_rd         <= rd_in;
                    wb_reg_write  <= reg_write_in & ~misaligned;
`ifdef MEM_MISALIGN_TRAP_EN
                    misalign_trap <= misaligned;
`endif
                end
            end
            if (wb_mem || timeout_hit) begin
                wb_valid      <= 1'b1;
                wb_alu        <= alu_q;
                wb_pc4        <= pc4_q;
                wb_mem_to_reg <= m2r_q;
                wb_rd         <= rd_q;
                wb_reg_write  <= reg_write_q & ~timeout_hit;
                bus_err       <= timeout_hit;
            end
            if (load_done) wb_load <= dmem.rdata;
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed self-checking bench for pipeline_mem_stage (TIMEOUT = 16).
module tb_pipeline_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] pc_t, pc4, alu, rs2;
    logic        zero, mem_read, mem_write, branch, jump, reg_write;
    logic [1:0]  m2r;
    logic [4:0]  rd;
    logic        stall_mem, pc_src;
    logic [31:0] pc_target;
    logic        wb_valid;
    logic [31:0] wb_alu, wb_load, wb_pc4;
    logic [1:0]  wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int checks = 0;
    int errors = 0;

    pipeline_mem_stage_if bus ();

    pipeline_mem_stage #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .PC_out_EX     (pc_t),
        .PC4_out_EX    (pc4),
        .ALU_out_EX    (alu),
        .Rs2_out_EX    (rs2),
        .zero_out_EX   (zero),
        .mem_read_in   (mem_read),
        .mem_write_in  (mem_write),
        .branch_in     (branch),
        .jump_in       (jump),
        .reg_write_in  (reg_write),
        .mem_to_reg_in (m2r),
        .rd_in         (rd),
        .stall_mem     (stall_mem),
        .pc_src        (pc_src),
        .pc_target     (pc_target),
        .dmem          (bus),
        .wb_valid      (wb_valid),
        .wb_alu        (wb_alu),
        .wb_load       (wb_load),
        .wb_pc4        (wb_pc4),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_trap (misalign_trap),
`endif
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; pc_t = 0; pc4 = 0; alu = 0; rs2 = 0; zero = 0;
        mem_read = 0; mem_write = 0; branch = 0; jump = 0; reg_write = 0;
        m2r = 0; rd = 0;
        bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] d, input logic ld,
                            input logic st, input logic rw, input logic [1:0] sel,
                            input logic [4:0] dst, input logic [31:0] p4);
        in_valid = 1; alu = a; rs2 = d; mem_read = ld; mem_write = st;
        reg_write = rw; m2r = sel; rd = dst; pc4 = p4;
        branch = 0; jump = 0; zero = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        step(); step();
        checks++;
        if ({stall_mem, pc_src, bus.req, bus.we, wb_valid, wb_reg_write, bus_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000000",
                     {stall_mem, pc_src, bus.req, bus.we, wb_valid, wb_reg_write, bus_err});
        end
        checks++;
        if ({pc_target, bus.addr, wb_alu, wb_load} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0", pc_target, bus.addr, wb_alu, wb_load);
        end
        rst_n = 1;
        step();
    endtask

    task automatic test_alu();
        drive_op(32'h5, 32'h0, 0, 0, 1, 2'd0, 5'd3, 32'h1004);
        step();
        clear_inputs();
        checks++;
        if ({wb_valid, wb_alu, wb_rd, wb_reg_write, wb_pc4} !== {1'b1, 32'h5, 5'd3, 1'b1, 32'h1004}) begin
            errors++;
            $display("FAIL alu_wb got v=%b alu=%h rd=%0d rw=%b pc4=%h exp v=1 alu=5 rd=3 rw=1 pc4=1004",
                     wb_valid, wb_alu, wb_rd, wb_reg_write, wb_pc4);
        end
        checks++;
        if (stall_mem !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall got %b exp 0", stall_mem);
        end
        step();
        checks++;
        if ({wb_valid, wb_alu} !== {1'b0, 32'h5}) begin
            errors++;
            $display("FAIL alu_hold got v=%b alu=%h exp v=0 alu=5", wb_valid, wb_alu);
        end
    endtask

    task automatic test_load();
        int stalls = 0;
        drive_op(32'h100, 32'h0, 1, 0, 1, 2'd1, 5'd7, 32'h2004);
        step();
        // cycle 1 in REQ: a live but unaccepted instruction must be ignored
        drive_op(32'hBAD, 32'h0, 0, 0, 1, 2'd0, 5'd9, 32'h0);
        stalls += int'(stall_mem);
        checks++;
        if ({bus.req, bus.we, bus.addr} !== {1'b1, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL load_req got req=%b we=%b addr=%h exp req=1 we=0 addr=100",
                     bus.req, bus.we, bus.addr);
        end
        step();
        clear_inputs();
        stalls += int'(stall_mem);
        bus.gnt = 1; bus.rvalid = 1; bus.rdata = 32'h11111111;
        step();
        bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
        stalls += int'(stall_mem);
        checks++;
        if ({bus.req, stall_mem, bus.addr} !== {1'b0, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL load_rsp got req=%b stall=%b addr=%h exp req=0 stall=1 addr=100",
                     bus.req, stall_mem, bus.addr);
        end
        step();
        stalls += int'(stall_mem);
        bus.rvalid = 1; bus.rdata = 32'hDEADBEEF;
        step();
        bus.rvalid = 0; bus.rdata = 0;
        stalls += int'(stall_mem);
        checks++;
        if (stalls !== 4) begin
            errors++;
            $display("FAIL load_stall_cycles got %0d exp 4", stalls);
        end
        checks++;
        if ({wb_valid, wb_load, wb_rd, wb_mem_to_reg, wb_reg_write, wb_alu}
            !== {1'b1, 32'hDEADBEEF, 5'd7, 2'd1, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL load_wb got v=%b load=%h rd=%0d sel=%0d rw=%b alu=%h exp v=1 load=deadbeef rd=7 sel=1 rw=1 alu=100",
                     wb_valid, wb_load, wb_rd, wb_mem_to_reg, wb_reg_write, wb_alu);
        end
        step();
    endtask

    task automatic test_store();
        drive_op(32'h104, 32'h12, 0, 1, 0, 2'd0, 5'd0, 32'h3004);
        step();
        clear_inputs();
        bus.gnt = 1;
        checks++;
        if ({bus.req, bus.we, bus.addr, bus.wdata} !== {1'b1, 1'b1, 32'h104, 32'h12}) begin
            errors++;
            $display("FAIL store_req got req=%b we=%b addr=%h wdata=%h exp req=1 we=1 addr=104 wdata=12",
                     bus.req, bus.we, bus.addr, bus.wdata);
        end
        step();
        bus.gnt = 0;
        checks++;
        if ({bus.req, bus.we, stall_mem, wb_valid, wb_reg_write, wb_load}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL store_wb got req=%b we=%b stall=%b v=%b rw=%b load=%h exp req=0 we=0 stall=0 v=1 rw=0 load=deadbeef",
                     bus.req, bus.we, stall_mem, wb_valid, wb_reg_write, wb_load);
        end
        step();
    endtask

    task automatic test_branch();
        drive_op(32'h0, 32'h0, 0, 0, 0, 2'd0, 5'd0, 32'h0);
        branch = 1; zero = 1; pc_t = 32'h40;
        step();
        drive_op(32'h0, 32'h0, 0, 0, 0, 2'd0, 5'd0, 32'h0);
        branch = 1; zero = 0; pc_t = 32'h80;
        checks++;
        if ({pc_src, pc_target} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL beq_taken got src=%b tgt=%h exp src=1 tgt=40", pc_src, pc_target);
        end
        step();
        drive_op(32'h0, 32'h0, 0, 0, 0, 2'd0, 5'd0, 32'h0);
        jump = 1; pc_t = 32'hC0;
        checks++;
        if ({pc_src, pc_target} !== {1'b0, 32'h80}) begin
            errors++;
            $display("FAIL beq_not_taken got src=%b tgt=%h exp src=0 tgt=80", pc_src, pc_target);
        end
        step();
        clear_inputs();
        jump = 1; pc_t = 32'hF0;
        checks++;
        if ({pc_src, pc_target} !== {1'b1, 32'hC0}) begin
            errors++;
            $display("FAIL jal got src=%b tgt=%h exp src=1 tgt=c0", pc_src, pc_target);
        end
        step();
        clear_inputs();
        checks++;
        if ({pc_src, pc_target} !== {1'b0, 32'hC0}) begin
            errors++;
            $display("FAIL jump_no_valid got src=%b tgt=%h exp src=0 tgt=c0", pc_src, pc_target);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        drive_op(32'h200, 32'h0, 1, 0, 1, 2'd1, 5'd9, 32'h4004);
        step();
        clear_inputs();
        while (stall_mem && n < 40) begin
            n++;
            step();
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL timeout_cycles got %0d exp 16", n);
        end
        checks++;
        if ({bus_err, wb_valid, wb_reg_write, wb_rd, stall_mem} !== {1'b1, 1'b1, 1'b0, 5'd9, 1'b0}) begin
            errors++;
            $display("FAIL timeout_wb got err=%b v=%b rw=%b rd=%0d stall=%b exp err=1 v=1 rw=0 rd=9 stall=0",
                     bus_err, wb_valid, wb_reg_write, wb_rd, stall_mem);
        end
        step();
        checks++;
        if ({bus_err, wb_valid} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse got err=%b v=%b exp 00", bus_err, wb_valid);
        end
    endtask

    task automatic test_misalign();
        drive_op(32'h103, 32'h0, 1, 0, 1, 2'd1, 5'd4, 32'h5004);
        step();
        clear_inputs();
`ifdef MEM_MISALIGN_TRAP_EN
        checks++;
        if ({bus.req, stall_mem, wb_valid, wb_reg_write, misalign_trap} !== 5'b00101) begin
            errors++;
            $display("FAIL misalign_trap got req=%b stall=%b v=%b rw=%b trap=%b exp 00101",
                     bus.req, stall_mem, wb_valid, wb_reg_write, misalign_trap);
        end
        step();
`else
        checks++;
        if ({bus.req, bus.addr} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL misalign_addr got req=%b addr=%h exp req=1 addr=100", bus.req, bus.addr);
        end
        bus.gnt = 1;
        step();
        bus.gnt = 0; bus.rvalid = 1; bus.rdata = 32'hCAFE0001;
        step();
        bus.rvalid = 0;
        checks++;
        if ({wb_valid, wb_load, wb_alu} !== {1'b1, 32'hCAFE0001, 32'h103}) begin
            errors++;
            $display("FAIL misalign_load got v=%b load=%h alu=%h exp v=1 load=cafe0001 alu=103",
                     wb_valid, wb_load, wb_alu);
        end
        step();
`endif
    endtask

    task automatic test_back_to_back();
        drive_op(32'hA1, 32'h0, 0, 0, 1, 2'd0, 5'd1, 32'h6004);
        step();
        drive_op(32'hB2, 32'h0, 0, 0, 1, 2'd2, 5'd2, 32'h6008);
        checks++;
        if ({wb_valid, wb_alu, wb_rd} !== {1'b1, 32'hA1, 5'd1}) begin
            errors++;
            $display("FAIL b2b_first got v=%b alu=%h rd=%0d exp v=1 alu=a1 rd=1", wb_valid, wb_alu, wb_rd);
        end
        step();
        clear_inputs();
        checks++;
        if ({wb_valid, wb_alu, wb_rd, wb_mem_to_reg, wb_pc4} !== {1'b1, 32'hB2, 5'd2, 2'd2, 32'h6008}) begin
            errors++;
            $display("FAIL b2b_second got v=%b alu=%h rd=%0d sel=%0d pc4=%h exp v=1 alu=b2 rd=2 sel=2 pc4=6008",
                     wb_valid, wb_alu, wb_rd, wb_mem_to_reg, wb_pc4);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        int seen = 0;
        drive_op(32'h300, 32'h0, 1, 0, 1, 2'd1, 5'd5, 32'h7004);
        step();
        clear_inputs();
        bus.gnt = 1;
        step();
        bus.gnt = 0;
        checks++;
        if ({bus.req, stall_mem} !== 2'b01) begin
            errors++;
            $display("FAIL rst_pre got req=%b stall=%b exp 01", bus.req, stall_mem);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({bus.req, stall_mem, wb_valid} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async got req=%b stall=%b v=%b exp 000", bus.req, stall_mem, wb_valid);
        end
        step();
        rst_n = 1;
        bus.rvalid = 1; bus.rdata = 32'h55AA55AA;
        for (int i = 0; i < 4; i++) begin
            step();
            seen += int'(wb_valid) + int'(stall_mem);
        end
        bus.rvalid = 0;
        checks++;
        if ({seen, wb_load} !== {32'd0, 32'h0}) begin
            errors++;
            $display("FAIL rst_no_wb got activity=%0d load=%h exp 0 0", seen, wb_load);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_timeout();
        test_misalign();
        test_back_to_back();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
